mult_scheduler: RTL

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mult_scheduler.sv
// mult_scheduler
//   Two requesters share one signed 8x8 shift-add multiplier. A request is
//   granted in an IDLE cycle using round-robin arbitration. The job then runs
//   through LOAD, eight ADD/SHIFT pairs and DONE. That gives a fixed latency
//   of 18 cycles from Grant to Done, and one job per 19 cycles back-to-back.
//
//   Handshake: a requester raises ReqN and holds its operands stable. In the
//   cycle where GrantN is high, AN/BN are captured, so the requester may
//   change or drop them from the next cycle on. DoneN pulses for one cycle
//   when Product holds that requester's result. Product then keeps that value
//   until the next job completes. Requests seen while Busy is high are ignored.
//
// Ports
//   Clk            system clock, rising edge
//   Reset_n        synchronous active-low reset
//   Req0/Req1      request lines, held until granted
//   A0/B0, A1/B1   signed 8-bit operands of requester 0/1
//   Grant0/Grant1  one-cycle pulse, operands captured this cycle
//   Done0/Done1    one-cycle pulse, Product valid for that requester
//   Product        signed 16-bit product of the last completed job
//   Busy           high from the grant cycle through DONE
//   Owner          requester index of the current or last job
module mult_scheduler (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [7:0]  A0,
    input  logic [7:0]  B0,
    input  logic [7:0]  A1,
    input  logic [7:0]  B1,
    output logic        Grant0,
    output logic        Grant1,
    output logic        Done0,
    output logic        Done1,
    output logic [15:0] Product,
    output logic        Busy,
    output logic        Owner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic        r_armed;
    logic        r_owner;
    logic        r_x;
    logic [7:0]  r_acc;
    logic [7:0]  r_mq;
    logic [7:0]  r_md;
    logic [2:0]  r_cnt;
    logic [15:0] r_product;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_grant;
    logic [8:0]  w_sum;
    logic [7:0]  w_acc_sh;
    logic [7:0]  w_mq_sh;

    // r_armed stays low for the first cycle after reset release. A request
    // that is still held therefore gets its grant one cycle later, not in the
    // release cycle itself.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (Reset_n && r_armed && (r_state == S_IDLE)) begin
            if (Req1 && (!Req0 || r_ptr)) begin
                w_gnt1 = 1'b1;
            end else if (Req0) begin
                w_gnt0 = 1'b1;
            end
        end
    end

    assign w_grant = w_gnt0 | w_gnt1;

    // The last iteration weighs the multiplier sign bit, so it subtracts.
    // Both operands are sign-extended to 9 bits, so the sum cannot overflow.
    always_comb begin
        w_sum = '0;
        if (r_cnt == 3'd7) begin
            w_sum = {r_acc[7], r_acc} - {r_md[7], r_md};
        end else begin
            w_sum = {r_acc[7], r_acc} + {r_md[7], r_md};
        end
    end

    // Arithmetic right shift of {X,Acc,Mq}. X keeps its value and supplies
    // the new sign bit of Acc.
    assign w_acc_sh = {r_x, r_acc[7:1]};
    assign w_mq_sh  = {r_acc[0], r_mq[7:1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_LOAD;
            S_LOAD:  w_next = S_ADD;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = (r_cnt == 3'd7) ? S_DONE : S_ADD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_armed   <= 1'b0;
            r_owner   <= 1'b0;
            r_x       <= 1'b0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_md      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_armed <= 1'b1;
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_md    <= w_gnt1 ? A1 : A0;
                        r_mq    <= w_gnt1 ? B1 : B0;
                        r_x     <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_owner <= w_gnt1;
                        // Point at the requester that lost this round.
                        r_ptr   <= w_gnt0;
                    end
                end
                S_ADD: begin
                    if (r_mq[0]) begin
                        {r_x, r_acc} <= w_sum;
                    end else begin
                        r_x <= r_acc[7];
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_sh;
                    r_mq  <= w_mq_sh;
                    r_cnt <= r_cnt + 3'd1;
                    // Load the result on the final shift, so Product is
                    // already valid in the cycle where Done pulses.
                    if (r_cnt == 3'd7) begin
                        r_product <= {w_acc_sh, w_mq_sh};
                    end
                end
                S_DONE: begin
                    r_product <= {r_acc, r_mq};
                end
                default: ;
            endcase
        end
    end

    assign Grant0  = w_gnt0;
    assign Grant1  = w_gnt1;
    assign Done0   = Reset_n && (r_state == S_DONE) && !r_owner;
    assign Done1   = Reset_n && (r_state == S_DONE) &&  r_owner;
    assign Busy    = Reset_n && (w_grant || (r_state != S_IDLE));
    assign Product = r_product;
    assign Owner   = r_owner;

endmodule
